// File: rtl/proc_run_pkg.sv
// Shared types and widths for the program run sequencer.
package proc_run_pkg;

    localparam int PC_W   = 64;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_SETTLE,
        ST_DONE,
        ST_TIMEOUT
    } run_state_t;

    // States in which the processor is being driven and the watchdog runs.
    function automatic logic is_busy_state(input run_state_t s);
        return (s == ST_RESET) || (s == ST_RUN) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/run_watchdog.sv
// Busy-cycle watchdog: clear/enable counter with a registered expired flag.
// The clear edge already counts the first busy cycle, so expired is high
// during the LIMIT-th busy cycle and the sequencer leaves on its closing edge.
module run_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] count;

    // Count busy cycles and flag the cycle in which the count equals LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (clr) begin
            count   <= W'(1);
            expired <= (LIM == W'(1));
        end else if (en && !expired) begin
            count   <= count + W'(1);
            expired <= ((count + W'(1)) == LIM);
        end
    end

endmodule

// File: rtl/proc_run_sequencer.sv
// Run controller for the single-cycle processor: resets it once, then walks a
// table of programs, waiting for each end PC and checking the data-memory
// result one cycle later. Reports pass count, fail mask and watchdog timeout.
module proc_run_sequencer
    import proc_run_pkg::*;
#(
    parameter int NUM_PROGS      = 2,
    parameter int RESET_CYCLES   = 1,
    parameter int WATCHDOG_LIMIT = 255
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        start,
    input  logic [PC_W-1:0]             start_pc,
    input  logic [PC_W*NUM_PROGS-1:0]   end_pcs,
    input  logic [DATA_W*NUM_PROGS-1:0] expect_vals,
    output logic                        proc_resetl,
    output logic [PC_W-1:0]             proc_startpc,
    input  logic [PC_W-1:0]             currentpc,
    input  logic [DATA_W-1:0]           dmemout,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic [CNT_W-1:0]            pass_count,
    output logic [NUM_PROGS-1:0]        fail_mask,
    output logic [IDX_W-1:0]            prog_idx
);

    localparam int RC_W = $clog2(RESET_CYCLES + 1);

    run_state_t           state, state_nxt;
    logic [IDX_W-1:0]     idx_nxt;
    logic [CNT_W-1:0]     pass_nxt;
    logic [NUM_PROGS-1:0] fail_nxt;
    logic [PC_W-1:0]      startpc_nxt;
    logic [RC_W-1:0]      rst_cnt, rst_cnt_nxt;
    logic                 wd_clr, wd_expired;
    logic [PC_W-1:0]      end_sel;
    logic [DATA_W-1:0]    exp_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    run_watchdog #(
        .LIMIT(WATCHDOG_LIMIT)
    ) u_watchdog (
        .clk    (CLK),
        .rst    (reset),
        .clr    (wd_clr),
        .en     (busy),
        .expired(wd_expired)
    );

    // Select the live table entry for the current program.
    always_comb begin
        end_sel = '0;
        exp_sel = '0;
        for (int i = 0; i < NUM_PROGS; i++) begin
            if (prog_idx == IDX_W'(i)) begin
                end_sel = end_pcs[i*PC_W +: PC_W];
                exp_sel = expect_vals[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-result logic; the watchdog overrides any check.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = prog_idx;
        pass_nxt    = pass_count;
        fail_nxt    = fail_mask;
        startpc_nxt = proc_startpc;
        rst_cnt_nxt = rst_cnt;
        wd_clr      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_nxt   = ST_RESET;
                    startpc_nxt = start_pc;
                    idx_nxt     = '0;
                    pass_nxt    = '0;
                    fail_nxt    = '0;
                    rst_cnt_nxt = '0;
                    wd_clr      = 1'b1;
                end
            end
            ST_RESET: begin
                if (wd_expired) begin
                    state_nxt = ST_TIMEOUT;
                end else if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    rst_cnt_nxt = rst_cnt + RC_W'(1);
                end
            end
            ST_RUN: begin
                if (wd_expired) begin
                    state_nxt = ST_TIMEOUT;
                end else if (currentpc >= end_sel) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wd_expired) begin
                    state_nxt = ST_TIMEOUT;
                end else begin
                    if (dmemout == exp_sel) begin
                        pass_nxt = sat_inc(pass_count);
                    end else begin
                        for (int i = 0; i < NUM_PROGS; i++) begin
                            if (prog_idx == IDX_W'(i)) fail_nxt[i] = 1'b1;
                        end
                    end
                    if (prog_idx == IDX_W'(NUM_PROGS - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = prog_idx + IDX_W'(1);
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, results and status outputs, all registered from the next state.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= ST_IDLE;
            proc_resetl  <= 1'b1;
            proc_startpc <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            pass_count   <= '0;
            fail_mask    <= '0;
            prog_idx     <= '0;
            rst_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            proc_resetl  <= (state_nxt != ST_RESET);
            proc_startpc <= startpc_nxt;
            busy         <= is_busy_state(state_nxt);
            done         <= (state_nxt == ST_DONE);
            timeout      <= (state_nxt == ST_TIMEOUT);
            pass_count   <= pass_nxt;
            fail_mask    <= fail_nxt;
            prog_idx     <= idx_nxt;
            rst_cnt      <= rst_cnt_nxt;
        end
    end

endmodule
